// File: rtl/filtros_pkg.sv
// Shared constants and elaboration-time helpers for the pixel filter blocks.
package filtros_pkg;

    localparam int unsigned BITS_PIXEL_DEF  = 8;
    localparam int unsigned TAM_VENTANA_MAX = 8;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < n) r++;
        return r;
    endfunction

    // Node count of tree level k for a window of n elements (level 0 is the window).
    function automatic int unsigned tam_nivel(input int unsigned n, input int unsigned k);
        return (n + (32'd1 << k) - 1) >> k;
    endfunction

    // Flat index of the first node of level k when all levels are laid out back to back.
    function automatic int unsigned base_nivel(input int unsigned n, input int unsigned k);
        int unsigned suma;
        suma = 0;
        for (int unsigned i = 0; i < k; i++) suma += tam_nivel(n, i);
        return suma;
    endfunction

endpackage

// File: rtl/comparador_num_mayor.sv
// Unsigned two-operand maximum; one instance per pair in the reduction tree.
module comparador_num_mayor
    import filtros_pkg::*;
#(
    parameter int unsigned BITS_NUMERO = BITS_PIXEL_DEF
) (
    input  logic [BITS_NUMERO-1:0] i_a,
    input  logic [BITS_NUMERO-1:0] i_b,
    output logic [BITS_NUMERO-1:0] o_mayor
);

    assign o_mayor = (i_a >= i_b) ? i_a : i_b;

endmodule

// File: rtl/filtro_maximo_ventana.sv
// Streaming 1-D sliding-window maximum with a registered comparator tree and
// valid/ready handshake; back-pressure freezes the whole pipeline.
module filtro_maximo_ventana
    import filtros_pkg::*;
#(
    parameter int unsigned BITS_NUMERO = BITS_PIXEL_DEF,
    parameter int unsigned TAM_VENTANA = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [BITS_NUMERO-1:0] entrada,
    input  logic                   entrada_valida,
    input  logic                   inicio_linea,
    output logic                   entrada_lista,
    output logic [BITS_NUMERO-1:0] salida,
    output logic                   salida_valida,
    input  logic                   salida_lista
);

    localparam int unsigned NIVELES     = clog2(TAM_VENTANA);
    localparam int unsigned NODOS       = base_nivel(TAM_VENTANA, NIVELES + 1);
    localparam int unsigned NODOS_ARBOL = NODOS - TAM_VENTANA;
    localparam int unsigned W_CONT      = clog2(TAM_VENTANA + 1);
    localparam logic [W_CONT-1:0] CONT_LLENO = W_CONT'(TAM_VENTANA);

    logic [TAM_VENTANA-1:0][BITS_NUMERO-1:0] r_ventana;
    logic [TAM_VENTANA-1:0][BITS_NUMERO-1:0] w_ventana_sig;
    logic [NODOS_ARBOL-1:0][BITS_NUMERO-1:0] r_arbol;
    logic [NODOS_ARBOL-1:0][BITS_NUMERO-1:0] w_arbol_sig;
    logic [NODOS-1:0][BITS_NUMERO-1:0]       w_nodos;
    logic [NIVELES:0]                        r_valido;
    logic [W_CONT-1:0]                       r_contador;
    logic [W_CONT-1:0]                       w_contador_sig;
    logic                                    w_valido_sig;
    logic                                    w_avanza;
    logic                                    w_acepta;

    assign w_avanza      = !r_valido[NIVELES] || salida_lista;
    assign w_acepta      = entrada_valida && w_avanza;
    assign entrada_lista = w_avanza;

    // Window at the low indices, then each tree level in order; the last node is the result.
    assign w_nodos       = {r_arbol, r_ventana};
    assign salida        = w_nodos[NODOS-1];
    assign salida_valida = r_valido[NIVELES];

    always_comb begin
        w_ventana_sig  = r_ventana;
        w_contador_sig = r_contador;
        w_valido_sig   = 1'b0;
        if (w_acepta) begin
            if (inicio_linea) begin
                w_ventana_sig  = '0;
                w_contador_sig = W_CONT'(1);
            end else begin
                for (int unsigned i = 1; i < TAM_VENTANA; i++)
                    w_ventana_sig[i] = r_ventana[i-1];
                if (r_contador != CONT_LLENO)
                    w_contador_sig = r_contador + 1'b1;
            end
            w_ventana_sig[0] = entrada;
            w_valido_sig     = (w_contador_sig == CONT_LLENO);
        end
    end

    for (genvar k = 1; k <= NIVELES; k++) begin : g_nivel
        localparam int unsigned N_ANT = tam_nivel(TAM_VENTANA, k - 1);
        localparam int unsigned N_ACT = tam_nivel(TAM_VENTANA, k);
        localparam int unsigned B_ANT = base_nivel(TAM_VENTANA, k - 1);
        localparam int unsigned B_ACT = base_nivel(TAM_VENTANA, k) - TAM_VENTANA;
        for (genvar j = 0; j < N_ACT; j++) begin : g_nodo
            if (2 * j + 1 < N_ANT) begin : g_par
                comparador_num_mayor #(
                    .BITS_NUMERO(BITS_NUMERO)
                ) u_comparador (
                    .i_a     (w_nodos[B_ANT + 2 * j]),
                    .i_b     (w_nodos[B_ANT + 2 * j + 1]),
                    .o_mayor (w_arbol_sig[B_ACT + j])
                );
            end else begin : g_impar
                assign w_arbol_sig[B_ACT + j] = w_nodos[B_ANT + 2 * j];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ventana  <= '0;
            r_arbol    <= '0;
            r_valido   <= '0;
            r_contador <= '0;
        end else if (w_avanza) begin
            r_ventana  <= w_ventana_sig;
            r_arbol    <= w_arbol_sig;
            r_valido   <= {r_valido[NIVELES-1:0], w_valido_sig};
            r_contador <= w_contador_sig;
        end
    end

endmodule
